// File: rtl/fpga_exit_uart_reporter.sv
// End-of-test reporter: latches the first exit value and sends "EXIT=XXXXXXXX\r\n"
// on an 8N1 UART line, then drives sticky pass/fail indications.
module fpga_exit_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 130
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o
);

  localparam int unsigned   BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_CHAR = 4'd14;

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      hex_ascii = 8'h30 + {4'h0, n};
    end else begin
      hex_ascii = 8'h37 + {4'h0, n};
    end
  endfunction

  // idx 5 selects nibble 7 (bits 31:28) down to idx 12 selecting nibble 0
  function automatic logic [7:0] char_of(input logic [3:0] idx, input logic [31:0] v);
    logic [2:0] nib;
    nib = 3'd4 - idx[2:0];
    case (idx)
      4'd0:    char_of = 8'h45;
      4'd1:    char_of = 8'h58;
      4'd2:    char_of = 8'h49;
      4'd3:    char_of = 8'h54;
      4'd4:    char_of = 8'h3D;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
               char_of = hex_ascii(v[{nib, 2'b00} +: 4]);
      4'd13:   char_of = 8'h0D;
      default: char_of = 8'h0A;
    endcase
  endfunction

  state_t        state_r, state_s;
  logic [BW-1:0] baud_r, baud_s;
  logic [2:0]    bit_r, bit_s;
  logic [3:0]    char_r, char_s;
  logic [31:0]   value_r, value_s;
  logic          valid_q_r;
  logic          tx_r, tx_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          pass_r, pass_s;
  logic          fail_r, fail_s;
  logic [7:0]    cur_char_s;
  logic          bit_end_s;

  // Next-state and next-output logic; outputs are computed one edge ahead and registered
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    bit_s      = bit_r;
    char_s     = char_r;
    value_s    = value_r;
    tx_s       = tx_r;
    busy_s     = busy_r;
    done_s     = done_r;
    pass_s     = pass_r;
    fail_s     = fail_r;
    cur_char_s = char_of(char_r, value_r);
    bit_end_s  = (baud_r == BAUD_LAST);

    if (state_r == START || state_r == DATA || state_r == STOP) begin
      baud_s = bit_end_s ? '0 : baud_r + BW'(1);
    end else begin
      baud_s = '0;
    end

    case (state_r)
      IDLE: begin
        if (exit_valid_i && !valid_q_r) begin
          value_s = exit_value_i;
          char_s  = 4'd0;
          bit_s   = 3'd0;
          busy_s  = 1'b1;
          tx_s    = 1'b0;
          state_s = START;
        end else begin
          tx_s = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          bit_s   = 3'd0;
          tx_s    = cur_char_s[0];
        end else begin
          tx_s = 1'b0;
        end
      end
      DATA: begin
        if (bit_end_s && bit_r == 3'd7) begin
          state_s = STOP;
          tx_s    = 1'b1;
        end else if (bit_end_s) begin
          bit_s = bit_r + 3'd1;
          tx_s  = cur_char_s[3'(bit_r + 3'd1)];
        end else begin
          tx_s = cur_char_s[bit_r];
        end
      end
      STOP: begin
        if (bit_end_s && char_r == LAST_CHAR) begin
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (value_r == 32'd0);
          fail_s  = (value_r != 32'd0);
          tx_s    = 1'b1;
        end else if (bit_end_s) begin
          char_s  = char_r + 4'd1;
          state_s = START;
          tx_s    = 1'b0;
        end else begin
          tx_s = 1'b1;
        end
      end
      DONE: begin
        tx_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        tx_s    = 1'b1;
      end
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      baud_r    <= '0;
      bit_r     <= 3'd0;
      char_r    <= 4'd0;
      value_r   <= 32'd0;
      valid_q_r <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      baud_r    <= baud_s;
      bit_r     <= bit_s;
      char_r    <= char_s;
      value_r   <= value_s;
      valid_q_r <= exit_valid_i;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      pass_r    <= pass_s;
      fail_r    <= fail_s;
    end
  end

  assign uart_tx_o = tx_r;
  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign pass_o    = pass_r;
  assign fail_o    = fail_r;

endmodule

// File: tb/tb_fpga_exit_uart_reporter.sv
// Directed bench for fpga_exit_uart_reporter: a UART monitor decodes the line
// and compares each byte against a scoreboard queue filled when a report is triggered.
module tb_fpga_exit_uart_reporter;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] value;
  logic        tx, busy, done, pass, fail;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];

  fpga_exit_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .exit_valid_i(valid),
    .exit_value_i(value),
    .uart_tx_o   (tx),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .fail_o      (fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_msg(input logic [31:0] v);
    string hexs = "0123456789ABCDEF";
    string pre  = "EXIT=";
    for (int i = 0; i < 5; i++) exp_q.push_back(pre[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hexs[v[4*i +: 4]]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Drive a one-cycle (or held) valid; returns at the negedge after the trigger edge.
  task automatic trigger(input logic [31:0] v, input logic hold);
    @(negedge clk);
    value = v;
    valid = 1'b1;
    push_msg(v);
    @(negedge clk);
    if (!hold) valid = 1'b0;
    check("start_busy", busy, 1);
    check("start_tx", tx, 0);
  endtask

  task automatic wait_done(input string tag, input int start, input logic exp_pass);
    int cycles = start;
    while (done !== 1'b1 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, cycles, 150 * CPB);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_fail"}, fail, !exp_pass);
  endtask

  task automatic idle_watch(input string tag, input int n);
    logic ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check({tag, "_idle_line"}, ok, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic do_reset(input logic valid_level);
    @(negedge clk);
    rst_n = 1'b0;
    valid = valid_level;
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // UART receiver: every sample of every bit must match, so bit length and gaps are checked
  initial begin : uart_monitor
    logic [7:0] b;
    logic [7:0] exp_byte;
    logic       ok;
    logic       abort;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        ok = 1'b1;
        abort = 1'b0;
        b = 8'h00;
        for (int s = 1; s < 10 * CPB; s++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) abort = 1'b1;
          if (s < CPB) begin
            if (tx !== 1'b0) ok = 1'b0;
          end else if (s < 9 * CPB) begin
            if ((s % CPB) == 0) b[(s / CPB) - 1] = tx;
            else if (tx !== b[(s / CPB) - 1]) ok = 1'b0;
          end else begin
            if (tx !== 1'b1) ok = 1'b0;
          end
        end
        if (!abort) begin
          if (exp_q.size() == 0) begin
            check("rx_extra_byte", exp_q.size(), 1);
          end else begin
            exp_byte = exp_q.pop_front();
            check("rx_byte", {23'd0, ok, b}, {23'd0, 1'b1, exp_byte});
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    valid = 1'b0;
    value = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx", tx, 1);

    // Nonzero exit value: fail indication after exactly 150 bit times
    trigger(32'h0000_002A, 1'b0);
    wait_done("t1", 0, 1'b0);
    idle_watch("t1", 20);

    // Valid already high at reset release triggers once
    do_reset(1'b1);
    value = 32'd0;
    push_msg(32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t2_start_busy", busy, 1);
    check("t2_start_tx", tx, 0);
    wait_done("t2", 0, 1'b1);
    idle_watch("t2", 60);
    valid = 1'b0;

    // Latched value survives input change; extra valid pulses ignored
    do_reset(1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    trigger(32'hDEAD_BEEF, 1'b0);
    repeat (100) @(negedge clk);
    value = 32'h1234_5678;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_done("t3", 101, 1'b0);
    @(negedge clk);
    value = 32'd0;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    idle_watch("t4", 100);
    check("t4_done_sticky", done, 1);

    // Asynchronous abort during data bits of char 6, then a clean restart
    do_reset(1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    trigger(32'h0000_FACE, 1'b0);
    repeat (250) @(negedge clk);
    check("t5_busy_before_abort", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_abort_tx", tx, 1);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_done", done, 0);
    exp_q.delete();
    repeat (50) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_idle_busy", busy, 0);
    check("t5_idle_tx", tx, 1);
    trigger(32'h0000_FACE, 1'b0);
    wait_done("t5", 0, 1'b0);
    idle_watch("t5", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
